// File: rtl/dmem_arbiter.sv
// Two-port (core / debug) data-memory arbiter with a two-state IDLE/ACCESS FSM.
// Define DMEM_ARB_RR_EN for round-robin arbitration; the default is fixed priority (core wins).
module dmem_arbiter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        core_req,
    input  logic        core_we,
    input  logic [9:0]  core_addr,
    input  logic [31:0] core_wdata,
    output logic        core_gnt,
    output logic        core_rvalid,
    output logic [31:0] core_rdata,
    input  logic        dbg_req,
    input  logic        dbg_we,
    input  logic [9:0]  dbg_addr,
    input  logic [31:0] dbg_wdata,
    output logic        dbg_gnt,
    output logic        dbg_rvalid,
    output logic [31:0] dbg_rdata,
    output logic [9:0]  mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [31:0] mem_rdata
);

    typedef enum logic {StIdle, StAccess} state_e;

    state_e      state_q, state_d;
    logic        core_gnt_q, core_gnt_d;
    logic        dbg_gnt_q, dbg_gnt_d;
    logic        core_rvalid_q, core_rvalid_d;
    logic        dbg_rvalid_q, dbg_rvalid_d;
    logic [31:0] core_rdata_q, core_rdata_d;
    logic [31:0] dbg_rdata_q, dbg_rdata_d;
    logic [9:0]  mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        mem_read_q, mem_read_d;
    logic        mem_write_q, mem_write_d;
    logic        pick_dbg;
    logic        win_we;

`ifdef DMEM_ARB_RR_EN
    // ptr_q = 1 favours the debug port on a tie.
    logic        ptr_q, ptr_d;
    assign pick_dbg = dbg_req & (~core_req | ptr_q);
`else
    assign pick_dbg = dbg_req & ~core_req;
`endif

    assign win_we = pick_dbg ? dbg_we : core_we;

    always_comb begin
        state_d       = state_q;
        core_gnt_d    = 1'b0;
        dbg_gnt_d     = 1'b0;
        core_rvalid_d = 1'b0;
        dbg_rvalid_d  = 1'b0;
        core_rdata_d  = core_rdata_q;
        dbg_rdata_d   = dbg_rdata_q;
        mem_addr_d    = '0;
        mem_wdata_d   = '0;
        mem_read_d    = 1'b0;
        mem_write_d   = 1'b0;
`ifdef DMEM_ARB_RR_EN
        ptr_d         = ptr_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (core_req || dbg_req) begin
                    state_d     = StAccess;
                    core_gnt_d  = ~pick_dbg;
                    dbg_gnt_d   = pick_dbg;
                    mem_addr_d  = pick_dbg ? dbg_addr : core_addr;
                    mem_wdata_d = pick_dbg ? dbg_wdata : core_wdata;
                    mem_read_d  = ~win_we;
                    mem_write_d = win_we;
`ifdef DMEM_ARB_RR_EN
                    ptr_d       = ~pick_dbg;
`endif
                end
            end
            StAccess: begin
                // Memory outputs are held in the mem_*_q flops, so this edge also returns them to 0.
                state_d       = StIdle;
                core_rvalid_d = core_gnt_q;
                dbg_rvalid_d  = dbg_gnt_q;
                if (core_gnt_q) core_rdata_d = mem_write_q ? 32'h0 : mem_rdata;
                if (dbg_gnt_q)  dbg_rdata_d  = mem_write_q ? 32'h0 : mem_rdata;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            core_gnt_q    <= 1'b0;
            dbg_gnt_q     <= 1'b0;
            core_rvalid_q <= 1'b0;
            dbg_rvalid_q  <= 1'b0;
            core_rdata_q  <= '0;
            dbg_rdata_q   <= '0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            mem_read_q    <= 1'b0;
            mem_write_q   <= 1'b0;
`ifdef DMEM_ARB_RR_EN
            ptr_q         <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            core_gnt_q    <= core_gnt_d;
            dbg_gnt_q     <= dbg_gnt_d;
            core_rvalid_q <= core_rvalid_d;
            dbg_rvalid_q  <= dbg_rvalid_d;
            core_rdata_q  <= core_rdata_d;
            dbg_rdata_q   <= dbg_rdata_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            mem_read_q    <= mem_read_d;
            mem_write_q   <= mem_write_d;
`ifdef DMEM_ARB_RR_EN
            ptr_q         <= ptr_d;
`endif
        end
    end

    assign core_gnt    = core_gnt_q;
    assign dbg_gnt     = dbg_gnt_q;
    assign core_rvalid = core_rvalid_q;
    assign dbg_rvalid  = dbg_rvalid_q;
    assign core_rdata  = core_rdata_q;
    assign dbg_rdata   = dbg_rdata_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign mem_read    = mem_read_q;
    assign mem_write   = mem_write_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a behavioural data memory.
// Expected grant order follows DMEM_ARB_RR_EN when it is defined.
module tb_dmem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        core_req, core_we, dbg_req, dbg_we;
    logic [9:0]  core_addr, dbg_addr;
    logic [31:0] core_wdata, dbg_wdata;
    logic        core_gnt, core_rvalid, dbg_gnt, dbg_rvalid;
    logic [31:0] core_rdata, dbg_rdata;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic        mem_read, mem_write;

    logic [31:0] mem [1024];
    logic        pre_we;
    logic [9:0]  pre_addr;
    logic [31:0] pre_data;

    int checks = 0;
    int failures = 0;

    dmem_arbiter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .core_req    (core_req),
        .core_we     (core_we),
        .core_addr   (core_addr),
        .core_wdata  (core_wdata),
        .core_gnt    (core_gnt),
        .core_rvalid (core_rvalid),
        .core_rdata  (core_rdata),
        .dbg_req     (dbg_req),
        .dbg_we      (dbg_we),
        .dbg_addr    (dbg_addr),
        .dbg_wdata   (dbg_wdata),
        .dbg_gnt     (dbg_gnt),
        .dbg_rvalid  (dbg_rvalid),
        .dbg_rdata   (dbg_rdata),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .mem_rdata   (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) begin
        if (mem_write) mem[mem_addr] <= mem_wdata;
        else if (pre_we) mem[pre_addr] <= pre_data;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [9:0] a, input logic [31:0] d);
        pre_we = 1'b1; pre_addr = a; pre_data = d;
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    // Called at a negedge with the FSM idle; returns at the negedge showing rvalid.
    task automatic run_txn(input bit is_dbg, input logic we, input logic [9:0] a,
                           input logic [31:0] wd, input logic [31:0] exp_rd, input string tag);
        int k;
        bit got;
        got = 1'b0;
        if (is_dbg) begin dbg_req = 1; dbg_we = we; dbg_addr = a; dbg_wdata = wd; end
        else begin core_req = 1; core_we = we; core_addr = a; core_wdata = wd; end
        for (k = 0; k < 8; k++) begin
            @(negedge clk);
            if ((is_dbg ? dbg_gnt : core_gnt) === 1'b1) begin got = 1'b1; break; end
        end
        check({tag, "_gnt"}, {31'b0, got}, 32'h1);
        check({tag, "_gnt_latency"}, k, 0);
        check({tag, "_mem_addr"}, {22'b0, mem_addr}, {22'b0, a});
        check({tag, "_mem_rw"}, {30'b0, mem_read, mem_write}, {30'b0, ~we, we});
        check({tag, "_other_gnt"}, {31'b0, is_dbg ? core_gnt : dbg_gnt}, 32'h0);
        core_req = 0; dbg_req = 0;
        @(negedge clk);
        check({tag, "_rvalid"}, {31'b0, is_dbg ? dbg_rvalid : core_rvalid}, 32'h1);
        check({tag, "_rdata"}, is_dbg ? dbg_rdata : core_rdata, exp_rd);
        check({tag, "_other_rvalid"}, {31'b0, is_dbg ? core_rvalid : dbg_rvalid}, 32'h0);
        check({tag, "_gnt_low"}, {30'b0, core_gnt, dbg_gnt}, 32'h0);
    endtask

    initial begin
        bit   seq [8];
        bit   exp_seq [8];
        int   nc, nd, ns, first_cyc, both_gnt, gnt_cnt, consec, both_rw;
        logic prev_gnt;

        rst_n = 0; pre_we = 0; pre_addr = '0; pre_data = '0;
        core_req = 0; core_we = 0; core_addr = '0; core_wdata = '0;
        dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0;
        @(negedge clk);
        preload(10'd0, 32'h0);
        preload(10'd3, 32'h0);
        preload(10'd5, 32'hDEADBEEF);
        preload(10'd7, 32'hA5A5A5A5);

        check("reset_gnt", {30'b0, core_gnt, dbg_gnt}, 32'h0);
        check("reset_rvalid", {30'b0, core_rvalid, dbg_rvalid}, 32'h0);
        check("reset_mem_rw", {30'b0, mem_read, mem_write}, 32'h0);
        check("reset_mem_addr", {22'b0, mem_addr}, 32'h0);
        check("reset_rdata_core", core_rdata, 32'h0);
        check("reset_rdata_dbg", dbg_rdata, 32'h0);
        rst_n = 1;
        @(negedge clk);

        // Core read, then debug write followed by a core read of the same word.
        run_txn(1'b0, 1'b0, 10'd5, 32'h0, 32'hDEADBEEF, "core_rd5");
        run_txn(1'b1, 1'b1, 10'd3, 32'h12345678, 32'h0, "dbg_wr3");
        check("core_rdata_hold", core_rdata, 32'hDEADBEEF);
        run_txn(1'b0, 1'b0, 10'd3, 32'h0, 32'h12345678, "core_rd3");
        check("dbg_rdata_hold", dbg_rdata, 32'h0);

        // Reset mid-ACCESS of a write to address 7.
        core_req = 1; core_we = 1; core_addr = 10'd7; core_wdata = 32'hCAFEF00D;
        @(negedge clk);
        check("abort_gnt", {31'b0, core_gnt}, 32'h1);
        check("abort_mem_write_before", {31'b0, mem_write}, 32'h1);
        #2 rst_n = 0;
        #1;
        check("abort_mem_write_async", {31'b0, mem_write}, 32'h0);
        check("abort_gnt_async", {31'b0, core_gnt}, 32'h0);
        check("abort_mem_addr", {22'b0, mem_addr}, 32'h0);
        core_req = 0; core_we = 0;
        @(negedge clk);
        check("abort_no_rvalid", {30'b0, core_rvalid, dbg_rvalid}, 32'h0);
        check("abort_rdata_cleared", core_rdata, 32'h0);

        // Both ports request across reset release; 4 reads each.
        core_req = 1; core_addr = 10'd5; dbg_req = 1; dbg_we = 0; dbg_addr = 10'd3;
        rst_n = 1;
        nc = 0; nd = 0; ns = 0; first_cyc = -1; both_gnt = 0;
        for (int cyc = 0; cyc < 40 && (nc < 4 || nd < 4); cyc++) begin
            @(negedge clk);
            if (core_gnt && dbg_gnt) both_gnt++;
            if (core_gnt || dbg_gnt) begin
                if (first_cyc < 0) first_cyc = cyc;
                if (ns < 8) seq[ns] = dbg_gnt;
                ns++;
            end
            if (core_gnt) begin nc++; if (nc == 4) core_req = 0; end
            if (dbg_gnt)  begin nd++; if (nd == 4) dbg_req = 0; end
        end
        core_req = 0; dbg_req = 0;
        check("sim_first_arb_cycle", first_cyc, 0);
        check("sim_both_gnt", both_gnt, 0);
        check("sim_core_cnt", nc, 4);
        check("sim_dbg_cnt", nd, 4);
        for (int i = 0; i < 8; i++) begin
`ifdef DMEM_ARB_RR_EN
            exp_seq[i] = i[0];
`else
            exp_seq[i] = (i >= 4);
`endif
        end
        for (int i = 0; i < 8; i++) check($sformatf("sim_order_%0d", i), {31'b0, seq[i]},
                                          {31'b0, exp_seq[i]});
        @(negedge clk);

        // Continuous core read of address 7 held for 6 cycles.
        core_req = 1; core_we = 0; core_addr = 10'd7;
        gnt_cnt = 0; consec = 0; both_rw = 0; prev_gnt = 0;
        for (int cyc = 0; cyc < 6; cyc++) begin
            @(negedge clk);
            if (core_gnt) gnt_cnt++;
            if (core_gnt && prev_gnt) consec++;
            if (mem_read && mem_write) both_rw++;
            prev_gnt = core_gnt;
        end
        core_req = 0;
        check("cont_gnt_cnt", gnt_cnt, 3);
        check("cont_consec_gnt", consec, 0);
        check("cont_both_rw", both_rw, 0);
        check("cont_rvalid", {31'b0, core_rvalid}, 32'h1);
        check("cont_rdata_aborted_write", core_rdata, 32'hA5A5A5A5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
